fetch_queue: RTL

Parametrised instruction-fetch front end with a decoupling queue between instruction memory and decode. It owns the fetch PC and issues one sequential instruction-memory read per cycle while queue credit is available. Returned words are buffered with their PCs in a DEPTH-entry FIFO and presented to decode over a valid/ready handshake. A branch/jump redirect flushes the queue and any in-flight read, then restarts fetch at the new address.

---
 rtl/fetch_queue.sv | 115 +++++++++++
 1 files changed

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: owns the fetch PC, issues sequential reads while
// queue credit remains, and buffers {pc, ir} pairs in a FIFO toward decode.
module fetch_queue #(
    parameter int              XLEN     = 32,
    parameter int              ILEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       fetch_en,
    input  logic                       redirect_en,
    input  logic [XLEN-1:0]            redirect_addr,
    output logic                       imem_req,
    output logic [XLEN-1:0]            imem_addr,
    input  logic [ILEN-1:0]            imem_rdata,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [XLEN-1:0]            out_pc,
    output logic [ILEN-1:0]            out_ir,
    output logic [$clog2(DEPTH):0]     q_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0] DEPTH_V = (CW+1)'(DEPTH);

    logic [XLEN-1:0] fpc_q, fpc_d;
    logic [XLEN-1:0] inflight_pc_q, inflight_pc_d;
    logic            inflight_q, inflight_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [XLEN-1:0] pc_q [DEPTH];
    logic [XLEN-1:0] pc_d [DEPTH];
    logic [ILEN-1:0] ir_q [DEPTH];
    logic [ILEN-1:0] ir_d [DEPTH];

    logic [CW:0] used;
    logic        push, pop;

    // Credit ignores a same-cycle pop so out_ready never reaches imem_req.
    assign used      = {1'b0, count_q} + (CW+1)'(inflight_q);
    assign imem_req  = fetch_en & ~redirect_en & ~rst & (used < DEPTH_V);
    assign imem_addr = fpc_q;
    assign out_valid = (count_q != '0);
    assign out_pc    = pc_q[rd_ptr_q];
    assign out_ir    = ir_q[rd_ptr_q];
    assign q_count   = count_q;

    assign push = inflight_q & ~redirect_en;
    assign pop  = out_valid & out_ready & ~redirect_en;

    always_comb begin
        fpc_d         = fpc_q;
        inflight_pc_d = inflight_pc_q;
        inflight_d    = 1'b0;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        count_d       = count_q;
        pc_d          = pc_q;
        ir_d          = ir_q;

        if (redirect_en) begin
            // The response landing this cycle belongs to the old stream; drop it.
            fpc_d    = {redirect_addr[XLEN-1:2], 2'b00};
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (imem_req) begin
                fpc_d         = fpc_q + XLEN'(4);
                inflight_d    = 1'b1;
                inflight_pc_d = fpc_q;
            end
            if (push) begin
                pc_d[wr_ptr_q] = inflight_pc_q;
                ir_d[wr_ptr_q] = imem_rdata;
                wr_ptr_d       = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fpc_q         <= RESET_PC;
            inflight_pc_q <= '0;
            inflight_q    <= 1'b0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_q[i] <= '0;
                ir_q[i] <= '0;
            end
        end else begin
            fpc_q         <= fpc_d;
            inflight_pc_q <= inflight_pc_d;
            inflight_q    <= inflight_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
            pc_q          <= pc_d;
            ir_q          <= ir_d;
        end
    end

endmodule
